fetch_queue: RTL and testbench

Instruction fetch unit with prefetch buffer, sitting directly upstream of the IF/ID pipeline register. It issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake. It buffers up to DEPTH fetched instructions with their PC and PC+4, and hands them to the ID stage under a valid/ready handshake driven by the pipeline stall logic. A branch/jump redirect flushes the buffer, discards any in-flight fetch, and restarts fetching at the target.

---
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch buffer between a req/ack
// instruction memory and the ID stage; redirects flush and restart fetching.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic [1:0]  dbg_state
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_drain_addr;

  logic          w_pop;
  logic          w_write;
  logic [AW:0]   w_count_next;
  logic [31:0]   w_target;

  // Handshakes: an ID transfer happens on a cycle with instr_valid & instr_ready
  // (a redirect cancels it); a memory transfer completes on a cycle with
  // imem_req & imem_ack, and imem_req/imem_addr never change before that.
  assign w_pop        = instr_valid & instr_ready & ~redirect;
  assign w_write      = (r_state == S_BUSY) & imem_ack & ~redirect;
  assign w_count_next = r_count + {{AW{1'b0}}, w_write} - {{AW{1'b0}}, w_pop};
  assign w_target     = redirect_pc & ~32'd3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= '0;
    end else if (redirect) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= w_target;
      case (r_state)
        S_BUSY: begin
          // The outstanding address must stay on the bus until the memory acks it.
          if (!imem_ack) begin
            r_state      <= S_DRAIN;
            r_drain_addr <= r_fetch_pc;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DRAIN: r_state <= imem_ack ? S_BUSY : S_DRAIN;
        default: r_state <= S_BUSY;
      endcase
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_write) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_count <= w_count_next;
      case (r_state)
        S_IDLE: if (r_count < FULL) r_state <= S_BUSY;
        S_BUSY: if (imem_ack) r_state <= (w_count_next < FULL) ? S_BUSY : S_IDLE;
        S_DRAIN: if (imem_ack) r_state <= S_BUSY;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  always_comb begin
    imem_req  = (r_state != S_IDLE);
    imem_addr = '0;
    if (r_state == S_BUSY)       imem_addr = r_fetch_pc;
    else if (r_state == S_DRAIN) imem_addr = r_drain_addr;
  end

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
  assign instr_pc    = instr_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
  assign instr_pc4   = instr_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'd0;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle plus
// directed scenarios with literal expectations; a second instance covers PC wrap.
module tb_fetch_queue;

  localparam int         DEPTH    = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       = 1'b1;
  logic        ack1        = 1'b0;
  logic [31:0] rdata1      = '0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready       = 1'b0;
  logic        req1, valid1;
  logic [31:0] addr1, instr1, pc1, pc4_1;
  logic [1:0]  dbg1;

  logic        ack2   = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2;
  logic [1:0]  dbg2;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int mem_cnt = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_ready(ready),
    .instr_valid(valid1), .instr(instr1), .instr_pc(pc1), .instr_pc4(pc4_1),
    .dbg_state(dbg1)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .redirect(1'b0), .redirect_pc(32'd0), .instr_ready(1'b1),
    .instr_valid(valid2), .instr(instr2), .instr_pc(pc2), .instr_pc4(pc4_2),
    .dbg_state(dbg2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endtask

  // Variable-latency memory: ack after `lat` cycles of a held request, data = f(addr).
  always @(negedge clk) begin
    if (reset || !req1) begin
      ack1    = 1'b0;
      mem_cnt = 0;
    end else if (mem_cnt + 1 >= lat) begin
      ack1    = 1'b1;
      rdata1  = word_of(addr1);
      mem_cnt = 0;
    end else begin
      ack1 = 1'b0;
      mem_cnt++;
    end
  end

  always @(negedge clk) begin
    ack2   = req2 && !reset;
    rdata2 = word_of(addr2);
  end

  // Reference model: buffered entries as a queue, plus the pending fetch.
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  bit          m_req  = 1'b0;
  bit          m_keep = 1'b0;
  logic [31:0] m_fpc  = 32'h0;
  logic [31:0] m_old  = 32'h0;

  always @(posedge clk or posedge reset) begin : model
    int   sz;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_req  = 1'b0;
      m_keep = 1'b0;
      m_fpc  = 32'h0;
      m_old  = 32'h0;
    end else if (redirect) begin
      m_q.delete();
      if (m_req && !ack1) begin
        if (m_keep) m_old = m_fpc;
        m_keep = 1'b0;
      end else begin
        m_keep = 1'b1;
      end
      m_req = 1'b1;
      m_fpc = redirect_pc & ~32'd3;
    end else begin
      sz = m_q.size();
      if (sz > 0 && ready) void'(m_q.pop_front());
      if (!m_req) begin
        m_req  = (sz < DEPTH);
        m_keep = 1'b1;
      end else if (ack1) begin
        if (m_keep) begin
          e.w  = rdata1;
          e.pc = m_fpc;
          m_q.push_back(e);
          m_fpc = m_fpc + 32'd4;
          m_req = (m_q.size() < DEPTH);
        end else begin
          m_keep = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        ev;
    logic [31:0] ei, ep;
    ev = (m_q.size() > 0);
    ei = ev ? m_q[0].w : 32'd0;
    ep = ev ? m_q[0].pc : 32'd0;
    check_bit("m_req", req1, m_req);
    if (m_req) check32("m_addr", addr1, m_keep ? m_fpc : m_old);
    check_bit("m_valid", valid1, ev);
    check32("m_instr", instr1, ei);
    check32("m_pc", pc1, ep);
    check32("m_pc4", pc4_1, ev ? ep + 32'd4 : 32'd0);
    check32("m_state", {30'd0, dbg1}, {30'd0, !m_req ? ST_IDLE : (m_keep ? ST_BUSY : ST_DRAIN)});
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    bit found;

    // Reset values and single-cycle streaming, with the wrapping instance alongside.
    lat   = 1;
    ready = 1'b1;
    cyc();
    check_bit("rst_req", req1, 1'b0);
    check32("rst_addr", addr1, 32'h0);
    check_bit("rst_valid", valid1, 1'b0);
    check32("rst_instr", instr1, 32'h0);
    check32("rst_pc4", pc4_1, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();
    check_bit("c1_req", req1, 1'b1);
    check32("c1_addr", addr1, 32'h0);
    check_bit("c1_valid", valid1, 1'b0);
    check32("wrap_c1_addr", addr2, 32'hFFFF_FFF8);
    cyc();
    check32("c2_pc", pc1, 32'h0);
    check32("c2_pc4", pc4_1, 32'h4);
    check32("c2_instr", instr1, word_of(32'h0));
    check32("wrap_c2_pc", pc2, 32'hFFFF_FFF8);
    cyc();
    check32("c3_pc", pc1, 32'h4);
    check32("wrap_c3_pc", pc2, 32'hFFFF_FFFC);
    check32("wrap_c3_pc4", pc4_2, 32'h0);
    cyc();
    check32("c4_pc", pc1, 32'h8);
    check32("wrap_c4_pc", pc2, 32'h0);
    check32("wrap_c4_pc4", pc4_2, 32'h4);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_bit("stream_valid", valid1, 1'b1);
      check32("stream_pc", pc1, 32'hC + 32'(i) * 4);
    end

    // Stalled ID stage fills the buffer, then drains in order and fetching resumes.
    ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    check32("full_state", {30'd0, dbg1}, {30'd0, ST_IDLE});
    check_bit("full_req", req1, 1'b0);
    check32("full_head", pc1, 32'h0);
    ready = 1'b1;
    cyc();
    check32("drain_pc4", pc1, 32'h4);
    cyc();
    check32("drain_pc8", pc1, 32'h8);
    check_bit("resume_req", req1, 1'b1);
    check32("resume_addr", addr1, 32'h10);
    cyc();
    check32("drain_pcC", pc1, 32'hC);
    cyc();
    check32("drain_pc10", pc1, 32'h10);

    // Redirect while a slow fetch is outstanding: old address held, its data dropped.
    lat   = 3;
    ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (req1 && addr1 == 32'h20) found = 1'b1;
    end
    if (!found) timeout("wait_req_20");
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    check_bit("drain_req", req1, 1'b1);
    check32("drain_addr", addr1, 32'h20);
    check32("drain_state", {30'd0, dbg1}, {30'd0, ST_DRAIN});
    check_bit("drain_valid", valid1, 1'b0);
    cyc();
    check32("target_addr", addr1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (valid1) found = 1'b1;
    end
    if (!found) timeout("wait_target_valid");
    check32("target_pc", pc1, 32'h100);

    // Redirect coincident with an ack and a ready head: nothing pops, data dropped.
    ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (!req1 && valid1) found = 1'b1;
    end
    if (!found) timeout("wait_full");
    check32("slow_full_head", pc1, 32'h0);
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (ack1 && addr1 == 32'h10) found = 1'b1;
    end
    if (!found) timeout("wait_ack_10");
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    ready       = 1'b1;
    cyc();
    redirect = 1'b0;
    ready    = 1'b0;
    check_bit("flush_valid", valid1, 1'b0);
    check_bit("flush_req", req1, 1'b1);
    check32("flush_addr", addr1, 32'h40);
    check32("flush_state", {30'd0, dbg1}, {30'd0, ST_BUSY});
    ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (valid1) found = 1'b1;
    end
    if (!found) timeout("wait_40_valid");
    check32("flush_pc", pc1, 32'h40);
    check32("flush_instr", instr1, word_of(32'h40));

    // Asynchronous reset during an outstanding slow request.
    cyc();
    check_bit("pre_reset_req", req1, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("async_req", req1, 1'b0);
    check32("async_addr", addr1, 32'h0);
    check_bit("async_valid", valid1, 1'b0);
    check32("async_instr", instr1, 32'h0);
    check32("async_pc", pc1, 32'h0);
    check32("async_pc4", pc4_1, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check_bit("restart_req", req1, 1'b1);
    check32("restart_addr", addr1, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (valid1) found = 1'b1;
    end
    if (!found) timeout("wait_restart_valid");
    check32("restart_pc", pc1, 32'h0);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
